// File: rtl/sram_act_pkg.sv
// Shared definitions for the activation SRAM family: clear-sweep states and the
// saturating accumulate used by every activation lane.
package sram_act_pkg;

    localparam int BW_PER_ACT_DEF = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Signed add clamped to a bw-bit two's-complement range (bw up to 30).
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 bw
    );
        logic signed [31:0] sum;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        sum   = a + b;
        max_v = (32'sd1 <<< (bw - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (bw - 1));
        if (sum > max_v) begin
            sat_add = max_v;
        end else if (sum < min_v) begin
            sat_add = min_v;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/act_sat_add.sv
// One activation lane: keeps, overwrites or saturating-accumulates a single
// signed activation.
module act_sat_add
    import sram_act_pkg::*;
#(
    parameter int BW = BW_PER_ACT_DEF
) (
    input  logic [BW-1:0] old_val,
    input  logic [BW-1:0] new_val,
    input  logic          mask,
    input  logic          acc,
    output logic [BW-1:0] next_val
);

    logic signed [31:0] old_ext;
    logic signed [31:0] new_ext;
    logic [BW-1:0]      sat_val;

    always_comb begin
        old_ext = {{(32-BW){old_val[BW-1]}}, old_val};
        new_ext = {{(32-BW){new_val[BW-1]}}, new_val};
        sat_val = BW'(sat_add(old_ext, new_ext, BW));
        if (mask) begin
            next_val = old_val;
        end else if (acc) begin
            next_val = sat_val;
        end else begin
            next_val = new_val;
        end
    end

endmodule

// File: rtl/sram_act_acc_dp.sv
// Activation SRAM, one write and one read port, with masked accumulate-on-write,
// a self-timed clear sweep and a sticky illegal-access flag.
module sram_act_acc_dp
    import sram_act_pkg::*;
#(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = BW_PER_ACT_DEF,
    parameter int DEPTH        = 18,
    parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int READ_LAT     = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      csb,
    input  logic                                      wsb,
    input  logic                                      acc,
    input  logic [CH_NUM*ACT_PER_ADDR-1:0]            wordmask,
    input  logic [AW-1:0]                             waddr,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] wdata,
    input  logic [AW-1:0]                             raddr,
    input  logic                                      clr,
    output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] rdata,
    output logic                                      rvalid,
    output logic                                      busy,
    output logic                                      err
);

    localparam int            NACT      = CH_NUM * ACT_PER_ADDR;
    localparam int            DW        = NACT * BW_PER_ACT;
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic          clr_accept;

    logic [DW-1:0] mem [DEPTH];

    logic          idle;
    logic          waddr_ok;
    logic          raddr_ok;
    logic          wr_en;
    logic          rd_en;
    logic          err_set;
    logic [DW-1:0] old_word;
    logic [DW-1:0] new_word;

    logic [DW-1:0] p1_data;
    logic          p1_valid;

    assign idle     = (state == IDLE);
    assign waddr_ok = ({1'b0, waddr} < DEPTH_LIM);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_LIM);
    assign wr_en    = idle && !csb && !wsb && waddr_ok;
    assign rd_en    = idle && !csb;
    assign old_word = waddr_ok ? mem[waddr] : '0;

    // Illegal: any access or clr during a sweep, or an out-of-range address in IDLE.
    assign err_set  = (!idle && (clr || !csb)) ||
                      (idle && !csb && (!raddr_ok || (!wsb && !waddr_ok)));

    for (genvar i = 0; i < NACT; i++) begin : g_lane
        act_sat_add #(
            .BW(BW_PER_ACT)
        ) u_lane (
            .old_val (old_word[i*BW_PER_ACT +: BW_PER_ACT]),
            .new_val (wdata[i*BW_PER_ACT +: BW_PER_ACT]),
            .mask    (wordmask[i]),
            .acc     (acc),
            .next_val(new_word[i*BW_PER_ACT +: BW_PER_ACT])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy       = 1'b0;
        clr_accept = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt  = CLEAR;
                    cnt_nxt    = '0;
                    clr_accept = 1'b1;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage has no reset so a mid-sweep reset leaves it partially cleared.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= new_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (clr_accept) begin
            err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_data  <= '0;
            p1_valid <= 1'b0;
        end else begin
            p1_valid <= rd_en;
            if (rd_en) begin
                p1_data <= raddr_ok ? mem[raddr] : '0;
            end
        end
    end

    if (READ_LAT >= 2) begin : g_lat2
        logic [DW-1:0] p2_data;
        logic          p2_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p2_data  <= '0;
                p2_valid <= 1'b0;
            end else begin
                p2_valid <= p1_valid;
                if (p1_valid) begin
                    p2_data <= p1_data;
                end
            end
        end

        assign rdata  = p2_data;
        assign rvalid = p2_valid;
    end else begin : g_lat1
        assign rdata  = p1_data;
        assign rvalid = p1_valid;
    end

endmodule
